// File: rtl/core_pkg.sv
// Shared types and helpers for the 8-bit core control path: FSM states,
// opcode classes and the relative-offset sign extension.
package core_pkg;

  localparam int CORE_W = 8;
  localparam int OFF_W  = 6;

  localparam int                WAIT_LIMIT_DEF = 15;
  localparam logic [CORE_W-1:0] HALT_INSN_DEF  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    UPDATE = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_BZ   = 2'b01;
  localparam logic [1:0] OP_JMP  = 2'b10;
  localparam logic [1:0] OP_MISC = 2'b11;

  function automatic logic [1:0] op_class(input logic [CORE_W-1:0] insn);
    return insn[CORE_W-1 -: 2];
  endfunction

  // Relative branch/jump offset: ir[5:0] as a two's-complement value -32..+31.
  function automatic logic [CORE_W-1:0] sext_offset(input logic [OFF_W-1:0] off);
    return {{(CORE_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive FETCH cycles without an acknowledge; expire flags the
// increment that brings the count up to WAIT_LIMIT.
module fetch_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int              CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
      expire  = (count_q == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Multicycle fetch/decode/execute/update controller for the 8-bit core.
// All control outputs are registered from the next-state decode.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int                DATA_W     = CORE_W,
  parameter int                WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter logic [DATA_W-1:0] HALT_INSN  = HALT_INSN_DEF
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] pc_addr,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              alu_en,
  input  logic              zero_flag,
  output logic              pc_step,
  output logic              pc_offset_bit,
  output logic [DATA_W-1:0] pc_offset,
  output logic              halted,
  output logic              fault
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] pc_offset_q, pc_offset_d;
  logic              mem_req_q, mem_req_d;
  logic              alu_en_q, alu_en_d;
  logic              pc_step_q, pc_step_d;
  logic              pc_offset_bit_q, pc_offset_bit_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic taken;
  logic wait_clr, wait_inc, wait_expire;

  // The timer only runs while we sit in FETCH waiting for the acknowledge.
  assign wait_inc = (state_q == FETCH) && !mem_ack;
  assign wait_clr = (state_q != FETCH) || mem_ack;

  fetch_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk   (CLK),
    .resetn(resetn),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .expire(wait_expire)
  );

  // Only meaningful in EXEC, which is the sole predecessor of UPDATE.
  always_comb begin
    taken = 1'b0;
    case (op_class(ir_q))
      OP_BZ:   taken = zero_flag;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = DECODE;
        end else if (wait_expire) begin
          fault_d = 1'b1;
          state_d = HALT;
        end
      end
      DECODE:  state_d = (ir_q == HALT_INSN) ? HALT : EXEC;
      EXEC:    state_d = UPDATE;
      UPDATE:  state_d = run ? FETCH : IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d       = (state_d == FETCH);
    alu_en_d        = (state_d == EXEC) && (op_class(ir_d) == OP_ALU);
    pc_step_d       = (state_d == UPDATE);
    pc_offset_bit_d = (state_d == UPDATE) && taken;
    pc_offset_d     = '0;
    if ((state_d == UPDATE) && taken) begin
      pc_offset_d = sext_offset(ir_q[OFF_W-1:0]);
    end
    halted_d        = (state_d == HALT);
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q         <= IDLE;
      ir_q            <= '0;
      pc_offset_q     <= '0;
      mem_req_q       <= 1'b0;
      alu_en_q        <= 1'b0;
      pc_step_q       <= 1'b0;
      pc_offset_bit_q <= 1'b0;
      halted_q        <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      pc_offset_q     <= pc_offset_d;
      mem_req_q       <= mem_req_d;
      alu_en_q        <= alu_en_d;
      pc_step_q       <= pc_step_d;
      pc_offset_bit_q <= pc_offset_bit_d;
      halted_q        <= halted_d;
      fault_q         <= fault_d;
    end
  end

  // The PC is frozen during FETCH, so the address can follow it directly.
  assign mem_addr      = pc_addr;
  assign mem_req       = mem_req_q;
  assign ir            = ir_q;
  assign alu_en        = alu_en_q;
  assign pc_step       = pc_step_q;
  assign pc_offset_bit = pc_offset_bit_q;
  assign pc_offset     = pc_offset_q;
  assign halted        = halted_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer; the bench plays the PC
// and program memory and predicts each instruction's effect arithmetically.
module tb_fetch_sequencer;

  logic       CLK = 1'b0;
  logic       resetn, run, mem_ack, zero_flag;
  logic [7:0] pc_addr, mem_rdata;
  logic       mem_req, alu_en, pc_step, pc_offset_bit, halted, fault;
  logic [7:0] mem_addr, ir, pc_offset;

  int checks = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  fetch_sequencer dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .run          (run),
    .pc_addr      (pc_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ir           (ir),
    .alu_en       (alu_en),
    .zero_flag    (zero_flag),
    .pc_step      (pc_step),
    .pc_offset_bit(pc_offset_bit),
    .pc_offset    (pc_offset),
    .halted       (halted),
    .fault        (fault)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Entry: DUT has just entered FETCH. Exit: one cycle after UPDATE.
  task automatic run_insn(input logic [7:0] insn, input logic zf, input int waits,
                          input logic run_after);
    int         soff;
    logic       taken;
    logic       is_alu;
    logic [7:0] exp_off, exp_pc, new_pc, old_pc;
    logic [5:0] off6;
    logic [1:0] cls;
    cls    = insn[7:6];
    off6   = insn[5:0];
    soff   = off6[5] ? int'(off6) - 64 : int'(off6);
    taken  = (cls == 2'b10) || ((cls == 2'b01) && zf);
    is_alu = (cls == 2'b00);
    old_pc = pc_addr;
    exp_off = taken ? 8'(soff) : 8'h00;
    exp_pc  = 8'((int'(pc_addr) + (taken ? soff : 1) + 256) % 256);

    for (int w = 0; w < waits; w++) begin
      mem_ack   = 1'b0;
      mem_rdata = 8'($urandom);
      check("wait_req", {7'd0, mem_req}, 8'd1);
      check("wait_addr", mem_addr, pc_addr);
      tick();
    end
    check("fetch_req", {7'd0, mem_req}, 8'd1);
    check("fetch_addr", mem_addr, pc_addr);
    mem_ack   = 1'b1;
    mem_rdata = insn;
    if (!run_after) run = 1'b0;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'($urandom);

    check("decode_ir", ir, insn);
    check("decode_quiet", {4'd0, mem_req, alu_en, pc_step, halted}, 8'd0);
    tick();

    if (insn == 8'hFF) begin
      check("halt_enter", {6'd0, halted, fault}, 8'b10);
      check("halt_quiet", {5'd0, mem_req, alu_en, pc_step}, 8'd0);
      $display("insn %02h pc %02h -> halted", insn, pc_addr);
      return;
    end

    zero_flag = zf;
    check("exec_alu_en", {7'd0, alu_en}, {7'd0, is_alu});
    check("exec_quiet", {6'd0, mem_req, pc_step}, 8'd0);
    tick();
    zero_flag = ~zf;

    check("upd_step", {7'd0, pc_step}, 8'd1);
    check("upd_offset_bit", {7'd0, pc_offset_bit}, {7'd0, taken});
    check("upd_offset", pc_offset, exp_off);
    check("upd_alu_off", {7'd0, alu_en}, 8'd0);
    new_pc  = pc_addr + (pc_offset_bit ? pc_offset : 8'd1);
    check("pc_result", new_pc, exp_pc);
    pc_addr = new_pc;
    tick();

    check("post_step", {7'd0, pc_step}, 8'd0);
    check("post_req", {7'd0, mem_req}, {7'd0, run_after});
    $display("insn %02h pc %02h -> %02h zf %0d waits %0d run %0d",
             insn, old_pc, pc_addr, zf, waits, run_after);
  endtask

  initial begin
    logic [7:0] insn;
    logic       ra;
    resetn    = 1'b0;
    run       = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    zero_flag = 1'b0;
    pc_addr   = 8'h10;
    tick();
    tick();
    check("rst_req", {7'd0, mem_req}, 8'd0);
    check("rst_ir", ir, 8'h00);
    check("rst_strobes", {4'd0, alu_en, pc_step, pc_offset_bit, halted}, 8'd0);
    check("rst_offset", pc_offset, 8'h00);
    check("rst_fault", {7'd0, fault}, 8'd0);

    resetn  = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'hA5;
    tick();
    check("idle_hold", {7'd0, mem_req}, 8'd0);
    check("idle_ack_ignored", ir, 8'h00);
    mem_ack = 1'b0;

    run = 1'b1;
    tick();
    check("start_req", {7'd0, mem_req}, 8'd1);

    run_insn(8'h05, 1'b0, 0, 1'b1);
    run_insn(8'h7E, 1'b1, 0, 1'b1);
    run_insn(8'h7E, 1'b0, 0, 1'b1);
    pc_addr = 8'hF0;
    run_insn(8'h9F, 1'b0, 0, 1'b1);
    pc_addr = 8'hFE;
    run_insn(8'h85, 1'b0, 0, 1'b1);
    run_insn(8'h80, 1'b1, 0, 1'b1);
    run_insn(8'hC3, 1'b1, 3, 1'b1);
    run_insn(8'h12, 1'b0, 14, 1'b0);
    tick();
    check("idle_park", {7'd0, mem_req}, 8'd0);
    run = 1'b1;
    tick();

    for (int i = 0; i < 24; i++) begin
      insn = 8'($urandom);
      if (insn == 8'hFF) insn = 8'hC0;
      ra = ($urandom_range(0, 3) != 0);
      run_insn(insn, 1'($urandom), int'($urandom_range(0, 3)), ra);
      if (!ra) begin
        run = 1'b1;
        tick();
      end
    end

    // Fetch timeout: fifteen unacknowledged FETCH cycles.
    mem_ack = 1'b0;
    for (int w = 0; w < 15; w++) begin
      check("to_req", {7'd0, mem_req}, 8'd1);
      check("to_not_halted", {7'd0, halted}, 8'd0);
      tick();
    end
    check("to_halted", {7'd0, halted}, 8'd1);
    check("to_fault", {7'd0, fault}, 8'd1);
    check("to_req_off", {7'd0, mem_req}, 8'd0);
    mem_ack = 1'b1;
    tick();
    tick();
    check("to_sticky", {6'd0, halted, fault}, 8'b11);
    check("to_req_still_off", {7'd0, mem_req}, 8'd0);
    mem_ack = 1'b0;

    resetn = 1'b0;
    tick();
    check("rst_clears_fault", {6'd0, halted, fault}, 8'd0);
    resetn = 1'b1;
    run    = 1'b1;
    tick();
    run_insn(8'hFF, 1'b0, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      mem_ack = 1'($urandom);
      tick();
      check("halt_stay", {7'd0, halted}, 8'd1);
      check("halt_quiet_k", {5'd0, mem_req, pc_step, fault}, 8'd0);
    end
    mem_ack = 1'b0;

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check("mid_fetch_req", {7'd0, mem_req}, 8'd1);
    resetn    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h55;
    tick();
    check("mid_rst_req", {7'd0, mem_req}, 8'd0);
    check("mid_rst_ir", ir, 8'h00);
    resetn = 1'b1;
    run    = 1'b0;
    tick();
    check("late_ack_req", {7'd0, mem_req}, 8'd0);
    check("late_ack_ir", ir, 8'h00);
    mem_ack = 1'b0;
    run     = 1'b1;
    tick();
    check("restart_req", {7'd0, mem_req}, 8'd1);
    run_insn(8'h01, 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multicycle control FSM for the 8-bit core.
- Fetches each instruction from program memory at the current PC with a req/ack handshake and latches it into the IR.
- Decodes the opcode class, strobes the ALU, and commands the PC to advance by +1 or by a sign-extended relative offset.
- Sits between the program counter, the program-memory port and the ALU control.

Parameters:
- DATA_W, 8, instruction/address width.
- WAIT_LIMIT, 15, maximum FETCH cycles without mem_ack before fault.
- HALT_INSN, 8'hFF, encoding that enters HALT.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous active-low reset.
- run  input  1  start/continue execution; sampled in IDLE and UPDATE.
- pc_addr  input  DATA_W  current PC value.
- mem_req  output  1  program-memory read request.
- mem_addr  output  DATA_W  read address, equal to pc_addr, valid while mem_req=1.
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  DATA_W  instruction byte.
- ir  output  DATA_W  instruction register.
- alu_en  output  1  one-cycle ALU execute strobe.
- zero_flag  input  1  ALU zero flag, sampled in EXEC.
- pc_step  output  1  one-cycle PC update enable.
- pc_offset_bit  output  1  1 = PC += pc_offset; 0 = PC += 1.
- pc_offset  output  DATA_W  sign-extended relative offset.
- halted  output  1  FSM in HALT.
- fault  output  1  fetch timeout occurred; sticky until reset.

Behaviour:
- Encoding: ir[7:6] is the class. 00 = ALU; 01 = BZ (branch if zero_flag); 10 = JMP (relative); 11 = NOP, except HALT_INSN. Offset = sign-extend of ir[5:0] to 8 bits (range -32..+31).
- resetn=0 at a clock edge forces:
  - state IDLE;
  - ir=0, all strobes 0, mem_req=0, pc_offset=0, halted=0, fault=0, wait counter=0.
  - This applies from any state, including mid-handshake; a late mem_ack after reset is ignored.
- IDLE: all strobes 0. run=1 -> FETCH on the next cycle.
- FETCH:
  - mem_req=1 and mem_addr=pc_addr, held stable until ack.
  - mem_ack=1 -> ir<=mem_rdata, counter cleared, go to DECODE.
  - Otherwise the counter increments. When it reaches WAIT_LIMIT without ack -> HALT with fault=1. An ack in that same cycle still wins.
- DECODE:
  - One cycle; no outputs asserted.
  - ir==HALT_INSN -> HALT; otherwise -> EXEC.
- EXEC:
  - ALU class: alu_en=1 for exactly this cycle.
  - BZ: latch taken=zero_flag.
  - JMP: taken=1.
  - NOP/ALU: taken=0.
- UPDATE:
  - pc_step=1 for exactly one cycle.
  - pc_offset_bit=taken; pc_offset=sext offset when taken, else 0.
  - Next state: run=1 -> FETCH; run=0 -> IDLE.
- HALT: halted=1, all other strobes 0. Exit only via reset.
- Timing and arithmetic:
  - Minimum latency is 4 cycles per instruction (ack in the first FETCH cycle); each wait cycle adds 1.
  - PC arithmetic is modulo 256 inside the PC. Offset 0 on JMP is a legal self-loop. Wrap from 8'hFE with +5 gives 8'h03.
- Deassertion of run in FETCH/DECODE/EXEC does not abort; the instruction completes and the FSM parks in IDLE.
- mem_ack outside FETCH is ignored.

Decomposition:
- Shared package (core_pkg):
  - state enum: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT;
  - opcode class constants: OP_ALU=2'b00, OP_BZ=2'b01, OP_JMP=2'b10, OP_MISC=2'b11;
  - HALT_INSN default;
  - sign-extend function.
- One sub-module, fetch_wait_timer: clearable up-counter with terminal flag at WAIT_LIMIT.

Test Plan:
- Reset, then run=1, ack same cycle, ir=8'h05 -> alu_en high exactly in cycle 3; pc_step in cycle 4 with pc_offset_bit=0; next mem_req in cycle 5.
- BZ ir=8'h7E (offset -2): zero_flag=1 -> pc_step with pc_offset_bit=1, pc_offset=8'hFE. Repeat with zero_flag=0 -> pc_offset_bit=0, pc_offset=0.
- JMP ir=8'h9F (+31) at pc_addr=8'hF0 -> pc_offset=8'h1F, offset_bit=1, resulting PC 8'h0F (wrap).
- mem_ack withheld 3 cycles -> mem_req and mem_addr stable for 4 cycles, ir loads on ack. Withheld for 15 cycles -> halted=1, fault=1, mem_req=0 afterwards.
- ir=8'hFF -> halted=1 after DECODE, no pc_step; stays halted with run=1 until resetn=0.
- resetn=0 during FETCH with mem_req=1 -> next cycle mem_req=0, state IDLE, ir=0; mem_ack asserted during reset has no effect.
